// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and writeback-source encodings.
package cpu_types_pkg;

  localparam int unsigned CPU_WORD_W    = 32;
  localparam int unsigned CPU_REGBITS_W = 5;

  typedef logic [CPU_WORD_W-1:0]    word_t;
  typedef logic [CPU_REGBITS_W-1:0] regbits_t;

  localparam logic [1:0] REGSRC_ALU = 2'b00;
  localparam logic [1:0] REGSRC_MEM = 2'b01;
  localparam logic [1:0] REGSRC_PC  = 2'b10;

  typedef struct packed {
    word_t      porto;
    word_t      dmemload;
    word_t      npc;
    regbits_t   wsel;
    logic [1:0] regsrc;
    logic       regen;
    logic       halt;
  } memwb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main register M drives the output, skid register S sits behind it.
// in_ready depends only on registered state, so there is no out_ready -> in_ready path.
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             accept;
  logic             m_free;

  assign in_ready  = ~s_valid_q;
  assign accept    = in_valid & ~s_valid_q;
  // M can take new contents when empty or when its current entry drains this cycle.
  assign m_free    = ~m_valid_q | out_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free && s_valid_q) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data_q;
      s_valid_d = accept;
      if (accept) begin
        s_data_d = in_data;
      end
    end else if (m_free) begin
      m_valid_d = accept;
      if (accept) begin
        m_data_d = in_data;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB pipeline register with valid/ready skid buffer, flush and $zero write masking.
// Define MEMWB_FWD_EN to add the combinational forwarding port (fwd_valid/fwd_wsel/fwd_data).
module memwb_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned REGSEL_W = 5,
  parameter int unsigned REGSRC_W = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   porto,
  input  logic [WORD_W-1:0]   dmemload,
  input  logic [WORD_W-1:0]   npc,
  input  logic [REGSEL_W-1:0] wsel,
  input  logic                regen,
  input  logic [REGSRC_W-1:0] regsrc,
  input  logic                halt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   porto_l,
  output logic [WORD_W-1:0]   dmemload_l,
  output logic [WORD_W-1:0]   npc_l,
  output logic [REGSEL_W-1:0] wsel_l,
  output logic [REGSRC_W-1:0] regsrc_l,
  output logic                regen_l,
  output logic                halt_l
`ifdef MEMWB_FWD_EN
  ,
  output logic                fwd_valid,
  output logic [REGSEL_W-1:0] fwd_wsel,
  output logic [WORD_W-1:0]   fwd_data
`endif
);

  localparam int unsigned PayloadW = 3 * WORD_W + REGSEL_W + REGSRC_W + 2;

  logic [PayloadW-1:0] in_payload;
  logic [PayloadW-1:0] out_payload;
  logic                m_regen;
  logic                m_halt;

  assign in_payload = {porto, dmemload, npc, wsel, regsrc, regen, halt};

  pipe_skid_buf #(
    .WIDTH(PayloadW)
  ) u_skid (
    .CLK      (CLK),
    .RST      (RST),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign {porto_l, dmemload_l, npc_l, wsel_l, regsrc_l, m_regen, m_halt} = out_payload;

  // Writes to $zero are suppressed here so WB never needs to special-case register 0.
  assign regen_l = m_regen & out_valid & (wsel_l != '0);
  assign halt_l  = m_halt & out_valid;

`ifdef MEMWB_FWD_EN
  assign fwd_valid = regen_l;
  assign fwd_wsel  = wsel_l;

  always_comb begin
    fwd_data = porto_l;
    if (regsrc_l == REGSRC_W'(REGSRC_MEM)) begin
      fwd_data = dmemload_l;
    end else if (regsrc_l == REGSRC_W'(REGSRC_PC)) begin
      fwd_data = npc_l;
    end
  end
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Directed, table-driven bench for memwb_stage plus hand sequences for reset, payload and forwarding.
module tb_memwb_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] porto = '0;
  logic [31:0] dmemload = '0;
  logic [31:0] npc = '0;
  logic [4:0]  wsel = '0;
  logic        regen = 1'b0;
  logic [1:0]  regsrc = '0;
  logic        halt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] porto_l, dmemload_l, npc_l;
  logic [4:0]  wsel_l;
  logic [1:0]  regsrc_l;
  logic        regen_l, halt_l;
`ifdef MEMWB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_wsel;
  logic [31:0] fwd_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  memwb_stage dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .porto     (porto),
    .dmemload  (dmemload),
    .npc       (npc),
    .wsel      (wsel),
    .regen     (regen),
    .regsrc    (regsrc),
    .halt      (halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .porto_l   (porto_l),
    .dmemload_l(dmemload_l),
    .npc_l     (npc_l),
    .wsel_l    (wsel_l),
    .regsrc_l  (regsrc_l),
    .regen_l   (regen_l),
    .halt_l    (halt_l)
`ifdef MEMWB_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_wsel  (fwd_wsel),
    .fwd_data  (fwd_data)
`endif
  );

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] din;
    logic [4:0]  ws;
    logic        re;
    logic        hl;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_porto;
    logic        e_regen;
    logic        e_halt;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs[NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // iv ordy fl din ws re hl | ov ir porto_l regen_l halt_l
    // Streaming with out_ready=1
    vecs[0]  = '{1, 1, 0, 32'h10,   5'd1, 1, 0, 1, 1, 32'h10,   1, 0};
    vecs[1]  = '{1, 1, 0, 32'h20,   5'd1, 1, 0, 1, 1, 32'h20,   1, 0};
    vecs[2]  = '{1, 1, 0, 32'h30,   5'd1, 1, 0, 1, 1, 32'h30,   1, 0};
    vecs[3]  = '{0, 1, 0, 32'h0,    5'd1, 1, 0, 0, 1, 32'h30,   0, 0};
    // Back-pressure: A in M, B in S, third refused, then drain in order
    vecs[4]  = '{1, 0, 0, 32'h11,   5'd2, 1, 0, 1, 1, 32'h11,   1, 0};
    vecs[5]  = '{1, 0, 0, 32'h22,   5'd2, 1, 0, 1, 0, 32'h11,   1, 0};
    vecs[6]  = '{1, 0, 0, 32'h99,   5'd2, 1, 0, 1, 0, 32'h11,   1, 0};
    vecs[7]  = '{0, 1, 0, 32'h0,    5'd2, 1, 0, 1, 1, 32'h22,   1, 0};
    vecs[8]  = '{0, 1, 0, 32'h0,    5'd2, 1, 0, 0, 1, 32'h22,   0, 0};
    // Flush with both entries full and a coincident input C=0x33
    vecs[9]  = '{1, 0, 0, 32'h44,   5'd3, 1, 0, 1, 1, 32'h44,   1, 0};
    vecs[10] = '{1, 0, 0, 32'h55,   5'd3, 1, 0, 1, 0, 32'h44,   1, 0};
    vecs[11] = '{1, 0, 1, 32'h33,   5'd3, 1, 0, 0, 1, 32'h44,   0, 0};
    vecs[12] = '{0, 1, 0, 32'h0,    5'd3, 1, 0, 0, 1, 32'h44,   0, 0};
    // $zero masking and halt qualification
    vecs[13] = '{1, 1, 0, 32'hDEAD, 5'd0, 1, 0, 1, 1, 32'hDEAD, 0, 0};
    vecs[14] = '{1, 1, 0, 32'hBEEF, 5'd5, 1, 0, 1, 1, 32'hBEEF, 1, 0};
    vecs[15] = '{1, 1, 0, 32'h1,    5'd5, 0, 1, 1, 1, 32'h1,    0, 1};
    vecs[16] = '{0, 1, 0, 32'h0,    5'd5, 0, 1, 0, 1, 32'h1,    0, 0};

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_regen_l",   32'(regen_l),   32'd0);
    chk("rst_halt_l",    32'(halt_l),    32'd0);
    chk("rst_porto_l",   porto_l,        32'd0);
    chk("rst_npc_l",     npc_l,          32'd0);
`ifdef MEMWB_FWD_EN
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_fwd_wsel",  32'(fwd_wsel),  32'd0);
    chk("rst_fwd_data",  fwd_data,       32'd0);
`endif
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    for (int i = 0; i < NVec; i++) begin
      in_valid  = vecs[i].iv;
      out_ready = vecs[i].ordy;
      flush     = vecs[i].fl;
      porto     = vecs[i].din;
      wsel      = vecs[i].ws;
      regen     = vecs[i].re;
      halt      = vecs[i].hl;
      step();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
      chk($sformatf("v%0d_porto_l", i),   porto_l,        vecs[i].e_porto);
      chk($sformatf("v%0d_regen_l", i),   32'(regen_l),   32'(vecs[i].e_regen));
      chk($sformatf("v%0d_halt_l", i),    32'(halt_l),    32'(vecs[i].e_halt));
    end
    flush = 1'b0;
    halt  = 1'b0;

    // Reset mid-stall with M and S full, then first accept after release
    in_valid = 1'b1; out_ready = 1'b0; regen = 1'b1; wsel = 5'd7;
    porto = 32'hA1; step();
    porto = 32'hB2; step();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_regen_l",   32'(regen_l),   32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_porto_l",   porto_l,        32'd0);
    @(negedge CLK);
    RST = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; porto = 32'h77;
    step();
    in_valid = 1'b0;
    chk("postrst_out_valid", 32'(out_valid), 32'd1);
    chk("postrst_porto_l",   porto_l,        32'h77);
    step();
    chk("postrst_drained", 32'(out_valid), 32'd0);

    // Full payload path
    in_valid = 1'b1; porto = 32'h1234_5678; dmemload = 32'hCAFE; npc = 32'h104;
    wsel = 5'd9; regsrc = 2'b01; regen = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pl_dmemload_l", dmemload_l,    32'hCAFE);
    chk("pl_npc_l",      npc_l,         32'h104);
    chk("pl_wsel_l",     32'(wsel_l),   32'd9);
    chk("pl_regsrc_l",   32'(regsrc_l), 32'd1);
    chk("pl_porto_l",    porto_l,       32'h1234_5678);
`ifdef MEMWB_FWD_EN
    chk("fwd_mem_valid", 32'(fwd_valid), 32'd1);
    chk("fwd_mem_wsel",  32'(fwd_wsel),  32'd9);
    chk("fwd_mem_data",  fwd_data,       32'hCAFE);
    in_valid = 1'b1; regsrc = 2'b10;
    step();
    chk("fwd_pc_data", fwd_data, 32'h104);
    regsrc = 2'b00;
    step();
    chk("fwd_alu_data", fwd_data, 32'h1234_5678);
    wsel = 5'd0;
    step();
    in_valid = 1'b0;
    chk("fwd_zero_valid", 32'(fwd_valid), 32'd0);
`endif
    step();
    chk("final_out_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
